// File: rtl/dm_responder_pkg.sv
// Shared definitions for the multi-cycle data-memory responder:
// access width codes, FSM state encoding and the stall level.
package dm_responder_pkg;

  localparam logic [1:0] memWidthWord = 2'd0;
  localparam logic [1:0] memWidthHalf = 2'd1;
  localparam logic [1:0] memWidthByte = 2'd2;

  // Level on stall that holds the M stage.
  localparam logic stallMemory = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dm_state_e;

  function automatic logic dm_misaligned(input logic [1:0] width, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (width == memWidthHalf) bad = addr_lo[0];
    else if (width == memWidthWord) bad = |addr_lo;
    return bad;
  endfunction

endpackage

// File: rtl/dm_responder_lane_align.sv
// Little-endian lane steering: store byte-enables/data replication and
// load lane extraction with sign or zero extension.
module dm_lane_align
  import dm_responder_pkg::*;
(
  input  logic [1:0]  width_i,
  input  logic [1:0]  addr_lo_i,
  input  logic        sign_ext_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_word_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    be_o    = 4'b1111;
    wdata_o = wdata_i;
    rdata_o = rdata_word_i;
    byte_v  = rdata_word_i[{addr_lo_i, 3'b000} +: 8];
    half_v  = addr_lo_i[1] ? rdata_word_i[31:16] : rdata_word_i[15:0];
    case (width_i)
      memWidthByte: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sign_ext_i & byte_v[7]}}, byte_v};
      end
      memWidthHalf: begin
        be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sign_ext_i & half_v[15]}}, half_v};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_word_i;
      end
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: one request at a time, fixed latency,
// single-cycle response pulse; stalls the M stage until completion.
//
// state | meaning
// IDLE  | ready; latch request on req_valid
// WAIT  | counting down the configured latency
// RESP  | response pulse; store commits at the closing edge
module dm_responder
  import dm_responder_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_width,
  input  logic        req_sign_ext,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        stall
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  dm_state_e             state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  write_q, sext_q, err_q;
  logic [1:0]            width_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [31:0]           mem_q [DEPTH];

  logic                  accept;
  logic                  req_err;
  logic                  mem_we;
  logic [3:0]            be;
  logic [31:0]           wdata_lanes;
  logic [31:0]           rd_word;
  logic [31:0]           ld_data;

  assign accept  = (state_q == IDLE) && req_valid;
  assign req_err = dm_misaligned(req_width, req_addr[1:0]) || (|(req_addr >> ADDR_WIDTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          cnt_d   = 4'(LATENCY);
          state_d = (LATENCY == 0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = RESP;
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_q <= 1'b0;
      width_q <= memWidthWord;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      write_q <= req_write;
      width_q <= req_width;
      sext_q  <= req_sign_ext;
      addr_q  <= req_addr[ADDR_WIDTH-1:0];
      wdata_q <= req_wdata;
      err_q   <= req_err;
    end
  end

  dm_lane_align u_align (
    .width_i      (width_q),
    .addr_lo_i    (addr_q[1:0]),
    .sign_ext_i   (sext_q),
    .wdata_i      (wdata_q),
    .rdata_word_i (rd_word),
    .be_o         (be),
    .wdata_o      (wdata_lanes),
    .rdata_o      (ld_data)
  );

  // Array has no reset; an async reset leaves RESP before the commit edge,
  // so an interrupted store never reaches it.
  assign mem_we  = (state_q == RESP) && write_q && !err_q;
  assign rd_word = mem_q[addr_q[ADDR_WIDTH-1:2]];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[addr_q[ADDR_WIDTH-1:2]][8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign resp_error = resp_valid && err_q;
  assign resp_rdata = (resp_valid && !write_q && !err_q) ? ld_data : 32'h0;
  assign stall      = (req_valid && !resp_valid) ? stallMemory : ~stallMemory;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: a LATENCY=2 instance for data/error/reset
// scenarios and a LATENCY=0 instance for back-to-back timing.
module tb_dm_responder;
  import dm_responder_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0, req_valid0 = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_width = memWidthWord;
  logic        req_sign_ext = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_error, stall;
  logic [31:0] resp_rdata;
  logic        req_ready0, resp_valid0, resp_error0, stall0;
  logic [31:0] resp_rdata0;

  int tests = 0;
  int fails = 0;
  bit tx_open = 1'b0;

  always #5 clk = ~clk;

  dm_responder #(.ADDR_WIDTH(12), .LATENCY(2)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_width(req_width), .req_sign_ext(req_sign_ext),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .stall(stall)
  );

  dm_responder #(.ADDR_WIDTH(12), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_write(req_write), .req_width(req_width), .req_sign_ext(req_sign_ext),
    .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid0),
    .resp_rdata(resp_rdata0), .resp_error(resp_error0), .stall(stall0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Requester must hold req_valid until the response arrives.
  always @(negedge clk) begin
    if (reset && tx_open && !req_valid) begin
      fails++;
      $error("FAIL protocol: req_valid dropped before response");
    end
  end

  // Full transaction on the LATENCY=2 instance, entered and left at a negedge.
  task automatic access(input string tag, input logic wr, input logic [1:0] w, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er);
    int  n;
    bit  got;
    bit  stall_ok;
    logic stall_at_resp;
    req_write = wr; req_width = w; req_sign_ext = sx; req_addr = a; req_wdata = wd;
    req_valid = 1'b1; tx_open = 1'b1;
    #1;
    check({tag, "_ready_T"}, {31'b0, req_ready}, 32'd1);
    n = 0; got = 1'b0; stall_ok = (stall === 1'b1); rd = '0; er = 1'b0; stall_at_resp = 1'b1;
    while (!got && n < 20) begin
      @(negedge clk); n++;
      if (resp_valid === 1'b1) begin
        got = 1'b1; rd = resp_rdata; er = resp_error; stall_at_resp = stall;
      end else if (stall !== 1'b1) stall_ok = 1'b0;
    end
    check({tag, "_latency"}, n, 32'd3);
    check({tag, "_stall_wait"}, {31'b0, stall_ok}, 32'd1);
    check({tag, "_stall_resp"}, {31'b0, stall_at_resp}, 32'd0);
    req_valid = 1'b0; tx_open = 1'b0;
    @(negedge clk);
    check({tag, "_ready_after"}, {31'b0, req_ready}, 32'd1);
  endtask

  logic [31:0] rd;
  logic        er;
  bit          seen;

  initial begin
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("rst_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_error", {31'b0, resp_error}, 32'd0);
    check("rst_stall", {31'b0, stall}, 32'd0);

    access("sw10", 1'b1, memWidthWord, 1'b0, 32'h10, 32'h12345678, rd, er);
    check("sw10_err", {31'b0, er}, 32'd0);
    access("lw10", 1'b0, memWidthWord, 1'b0, 32'h10, 32'h0, rd, er);
    check("lw10_data", rd, 32'h12345678);

    access("sb11", 1'b1, memWidthByte, 1'b0, 32'h11, 32'h80, rd, er);
    access("lb11", 1'b0, memWidthByte, 1'b1, 32'h11, 32'h0, rd, er);
    check("lb11_data", rd, 32'hFFFFFF80);
    access("lbu11", 1'b0, memWidthByte, 1'b0, 32'h11, 32'h0, rd, er);
    check("lbu11_data", rd, 32'h00000080);
    access("lw10b", 1'b0, memWidthWord, 1'b0, 32'h10, 32'h0, rd, er);
    check("lw10b_data", rd, 32'h12348078);
    access("lh12", 1'b0, memWidthHalf, 1'b1, 32'h12, 32'h0, rd, er);
    check("lh12_data", rd, 32'h00001234);
    access("lh10", 1'b0, memWidthHalf, 1'b1, 32'h10, 32'h0, rd, er);
    check("lh10_data", rd, 32'hFFFF8078);

    access("lh11", 1'b0, memWidthHalf, 1'b1, 32'h11, 32'h0, rd, er);
    check("lh11_err", {31'b0, er}, 32'd1);
    check("lh11_data", rd, 32'h0);
    access("sw12", 1'b1, memWidthWord, 1'b0, 32'h12, 32'hAAAA5555, rd, er);
    check("sw12_err", {31'b0, er}, 32'd1);
    access("lw1000", 1'b0, memWidthWord, 1'b0, 32'h1000, 32'h0, rd, er);
    check("lw1000_err", {31'b0, er}, 32'd1);
    check("lw1000_data", rd, 32'h0);
    access("lw10c", 1'b0, memWidthWord, 1'b0, 32'h10, 32'h0, rd, er);
    check("lw10c_data", rd, 32'h12348078);
    check("lw10c_err", {31'b0, er}, 32'd0);

    req_write = 1'b1; req_width = memWidthWord; req_addr = 32'h10; req_wdata = 32'hDEADBEEF;
    req_valid = 1'b1; tx_open = 1'b1;
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0; tx_open = 1'b0;
    #1;
    check("midrst_ready", {31'b0, req_ready}, 32'd1);
    @(negedge clk);
    reset = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    check("midrst_no_resp", {31'b0, seen}, 32'd0);
    access("lw10d", 1'b0, memWidthWord, 1'b0, 32'h10, 32'h0, rd, er);
    check("lw10d_data", rd, 32'h12348078);

    req_write = 1'b1; req_width = memWidthWord; req_addr = 32'h20; req_wdata = 32'hCAFEF00D;
    req_valid0 = 1'b1;
    @(negedge clk);
    check("l0_sw_resp", {31'b0, resp_valid0}, 32'd1);
    req_valid0 = 1'b0;
    @(negedge clk);
    req_write = 1'b0; req_valid0 = 1'b1;
    #1;
    check("b2b_T_ready", {31'b0, req_ready0}, 32'd1);
    check("b2b_T_resp", {31'b0, resp_valid0}, 32'd0);
    @(negedge clk);
    check("b2b_T1_resp", {31'b0, resp_valid0}, 32'd1);
    check("b2b_T1_ready", {31'b0, req_ready0}, 32'd0);
    check("b2b_T1_data", resp_rdata0, 32'hCAFEF00D);
    check("b2b_T1_stall", {31'b0, stall0}, 32'd0);
    @(negedge clk);
    check("b2b_T2_ready", {31'b0, req_ready0}, 32'd1);
    check("b2b_T2_resp", {31'b0, resp_valid0}, 32'd0);
    check("b2b_T2_stall", {31'b0, stall0}, 32'd1);
    @(negedge clk);
    check("b2b_T3_resp", {31'b0, resp_valid0}, 32'd1);
    check("b2b_T3_ready", {31'b0, req_ready0}, 32'd0);
    check("b2b_T3_data", resp_rdata0, 32'hCAFEF00D);
    req_valid0 = 1'b0;
    @(negedge clk);
    check("b2b_T4_ready", {31'b0, req_ready0}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
# dm_responder

Multi-cycle data-memory responder for the M stage of the pipelined MIPS core. It accepts one load/store request at a time from the memory stage and holds the core in `stallMemory` until the access completes. After a configurable latency it returns a single-cycle response carrying the aligned, extended read data or an error flag. It replaces the zero-wait-state data memory so the pipeline's memory-stall path is exercised.

## Interface

- `ADDR_WIDTH`, default 12: byte-address bits decoded; the array holds 2^(ADDR_WIDTH-2) words.
- `LATENCY`, default 2: wait cycles between accept and response, legal range 0..15.

Ports (name, direction, width, meaning):

- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present; the requester holds it and all `req_*` stable until `resp_valid`.
- `req_ready` out 1: responder idle and able to accept.
- `req_write` in 1: 1 = store, 0 = load.
- `req_width` in 2: access width, one of `memWidthWord`, `memWidthHalf`, `memWidthByte` (package constants).
- `req_sign_ext` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-justified.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: load result, valid with `resp_valid`; 0 otherwise.
- `resp_error` out 1: misaligned or out-of-range access, valid with `resp_valid`.
- `stall` out 1: `req_valid & ~resp_valid`; drives the M-stage data-waiting input.

## Operation

- States are `IDLE`, `WAIT` and `RESP`.
- `IDLE`: `req_ready`=1. When `req_valid`=1, latch the request and load the counter with `LATENCY`. Go to `WAIT` if `LATENCY`>0, otherwise go to `RESP`.
- `WAIT`: decrement the counter each cycle. When it reaches 1, go to `RESP`.
- `RESP`: `resp_valid`=1, perform the array access, then return to `IDLE` the next cycle.
- Back-to-back requests: a request presented in the cycle after `RESP` is accepted in that cycle.
- Error conditions, decoded at latch:
  - Half access with addr[0]≠0.
  - Word access with addr[1:0]≠0.
  - Any bit of addr[31:ADDR_WIDTH] set.
  - On error: no write, `resp_rdata`=0, `resp_error`=1.
- Byte lanes are little-endian. A byte access uses lane addr[1:0]; a half access uses lanes {addr[1],0}..{addr[1],1}.
- Stores replace only the addressed lanes with the low bits of `req_wdata`.
- Loads extract the addressed lanes and extend per `req_sign_ext`. Word loads ignore `req_sign_ext`.
- The array is not cleared by reset.

## Timing

- Accept in cycle T; `resp_valid` in cycle T+1+`LATENCY`; `req_ready` is high again in cycle T+2+`LATENCY`.
- The store commits at the rising edge ending the `RESP` cycle. A load issued later observes it.
- `stall` is combinational and deasserts in the `RESP` cycle, so the M stage advances on that edge.
- Reset values: state `IDLE`, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_error`=0, counter 0.
- Reset asserted mid-operation (in `WAIT` or `RESP`, before the commit edge):
  - The request is dropped and no write occurs.
  - No response is issued.
- `req_valid` dropping before the response is a protocol violation. The behaviour is undefined; the bench asserts that it never happens.

## Structure

- A shared package holds:
  - the width codes: `memWidthWord`=0, `memWidthHalf`=1, `memWidthByte`=2;
  - the state encoding `IDLE`/`WAIT`/`RESP`;
  - the `stallMemory` level.
- One combinational sub-module, `dm_lane_align`, does store lane merging (byte-enable and data) and load extraction/extension.
- FSM, counter and array stay in `dm_responder`.

## Test plan

- Reset: drive `reset` low, then high with `req_valid`=0 → `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_error`=0, `stall`=0.
- Word round-trip (`LATENCY`=2):
  - SW 0x12345678 @0x10 accepted in T → `resp_valid` in T+3, `stall` high T..T+2.
  - LW @0x10 → `resp_rdata`=0x12345678.
- Byte/half:
  - SB 0x80 @0x11 → LB @0x11 = 0xFFFFFF80, LBU = 0x00000080, LW @0x10 = 0x12348078.
  - LH @0x12 sign-extended = 0xFFFF1234 only if bit15 is set; here it returns 0x00001234.
- Errors: LH @0x11, SW @0x12 and LW @0x1000 (`ADDR_WIDTH`=12) → `resp_error`=1, `resp_rdata`=0, and a following LW @0x10 is unchanged.
- Reset mid-store: SW 0xDEADBEEF @0x10, with reset pulsed in a `WAIT` cycle → no `resp_valid`, and LW @0x10 afterwards still returns the old value.
- `LATENCY`=0, back-to-back loads held on `req_valid` → responses in T+1 and T+3, with `req_ready` high only in T and T+2.
